// File: rtl/control_gnr_param_if.sv
// -----------------------------------------------------------------------------
// control_gnr_param_if
//
// Bundles every signal between the attractor-search controller and its
// surroundings: the two network simulation cores, the input range FIFO and
// the output result FIFO.
//
// Parameters:
//   NODES  network width in bits
//   CNT_W  width of the transient and period counters
//
// Signals (direction seen from the controller, modport master):
//   s0, s1          in   tortoise / hare core state
//   fifo_in_empty   in   input FIFO empty
//   fifo_in_data    in   range word {end, start}
//   end_data_in     in   no further input will arrive
//   fifo_in_re      out  input FIFO read pulse
//   fifo_out_full   in   output FIFO full
//   fifo_out_empty  in   output FIFO empty
//   fifo_out_we     out  output FIFO write pulse
//   fifo_out_data   out  record {timeout, state_net, transient, period}
//   reset_nos       out  load init_state into both cores
//   start_s0        out  advance the tortoise one step
//   start_s1        out  advance the hare
//   s1_single       out  hare mode: 0 = two steps, 1 = one step per cycle
//   init_state      out  current initial state
// The slave modport is the mirror image, used by the FIFOs/cores side.
// -----------------------------------------------------------------------------
interface control_gnr_param_if #(
  parameter int NODES = 188,
  parameter int CNT_W = 29
);
  localparam int REC_W = NODES + 2 * CNT_W + 1;

  logic [NODES-1:0]   s0;
  logic [NODES-1:0]   s1;
  logic               fifo_in_empty;
  logic [2*NODES-1:0] fifo_in_data;
  logic               end_data_in;
  logic               fifo_in_re;
  logic               fifo_out_full;
  logic               fifo_out_empty;
  logic               fifo_out_we;
  logic [REC_W-1:0]   fifo_out_data;
  logic               reset_nos;
  logic               start_s0;
  logic               start_s1;
  logic               s1_single;
  logic [NODES-1:0]   init_state;

  modport master (
    input  s0, s1, fifo_in_empty, fifo_in_data, end_data_in,
           fifo_out_full, fifo_out_empty,
    output fifo_in_re, fifo_out_we, fifo_out_data, reset_nos,
           start_s0, start_s1, s1_single, init_state
  );

  modport slave (
    output s0, s1, fifo_in_empty, fifo_in_data, end_data_in,
           fifo_out_full, fifo_out_empty,
    input  fifo_in_re, fifo_out_we, fifo_out_data, reset_nos,
           start_s0, start_s1, s1_single, init_state
  );
endinterface

// File: rtl/control_gnr_param.sv
// -----------------------------------------------------------------------------
// control_gnr_param
//
// Attractor-search controller for the Boolean gene-regulatory-network
// accelerator. For every initial state in each {end, start} range word read
// from the input FIFO it runs Floyd cycle detection on a tortoise core (s0,
// one step per cycle) and a hare core (s1, two steps per cycle), then measures
// the attractor period by single-stepping the hare around the cycle, and
// writes one record {timeout, state_net, transient, period} to the output FIFO.
//
// Parameters:
//   ID         instance index (simulation identification only)
//   NODES      network width in bits
//   CNT_W      width of the transient and period counters
//   MAX_STEPS  step limit, used only with the timeout compiled in
//
// Build option:
//   CONTROL_GNR_PARAM_TIMEOUT_EN  when defined, FIND or PERIOD reaching
//   MAX_STEPS aborts the search and emits a record with timeout=1. When
//   undefined there is no limit, counters wrap and the timeout bit is 0.
//
// Ports:
//   clk    clock
//   rst    asynchronous active-high reset
//   start  enable; low freezes all state and masks the three pulse outputs
//   bus    controller side (master) of control_gnr_param_if
//   done   sticky completion flag: input ended and output drained
// -----------------------------------------------------------------------------
module control_gnr_param #(
  parameter int          ID        = 0,
  parameter int          NODES     = 188,
  parameter int          CNT_W     = 29,
  parameter int unsigned MAX_STEPS = (2 ** CNT_W) - 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  control_gnr_param_if.master bus,
  output logic                done
);

  localparam int REC_W = NODES + 2 * CNT_W + 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_GET_STATE = 3'd1;
  localparam logic [2:0] ST_RESET_NOS = 3'd2;
  localparam logic [2:0] ST_START_NOS = 3'd3;
  localparam logic [2:0] ST_FIND      = 3'd4;
  localparam logic [2:0] ST_PERIOD    = 3'd5;
  localparam logic [2:0] ST_EMIT      = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  // Parameter sanity guard; the block is empty for any legal configuration.
  if (ID < 0 || MAX_STEPS == 0) begin : g_param_guard
  end

  logic [2:0]       state;
  // First-cycle marker shared by GET_STATE, FIND and PERIOD: 0 on the first
  // cycle in the state, 1 afterwards.
  logic             phase;
  logic             fifo_in_re_q;
  logic             fifo_out_we_q;
  logic             reset_nos_q;
  logic             start_s0_q;
  logic             start_s1_q;
  logic             s1_single_q;
  logic [NODES-1:0] init_state_q;
  logic [NODES-1:0] end_reg;
  logic [NODES-1:0] state_net;
  logic [CNT_W-1:0] transient;
  logic [CNT_W-1:0] period;
  logic             timeout_q;
  logic [REC_W-1:0] out_data_q;
  logic             drain_seen;
  logic             done_q;

  logic find_hit;
  logic period_hit;
  logic step_abort;
  logic core_stop;

  // On the first cycle of FIND both cores still hold init_state, so the
  // comparison is only meaningful from the second cycle on.
  assign find_hit   = (state == ST_FIND)   && phase && (bus.s0 == bus.s1);
  assign period_hit = (state == ST_PERIOD) && phase && (bus.s1 == state_net);

`ifdef CONTROL_GNR_PARAM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] STEP_LIMIT = CNT_W'(MAX_STEPS);

  // A genuine match on the same cycle wins over the limit.
  assign step_abort = ((state == ST_FIND)   && !find_hit   && (transient == STEP_LIMIT)) ||
                      ((state == ST_PERIOD) && !period_hit && (period    == STEP_LIMIT));
`else
  assign step_abort = 1'b0;
`endif

  // The step enables are registered, so on a detection cycle they would
  // still be high and the cores would take one more step at the same edge.
  // Masking them combinationally freezes the cores exactly on the matching
  // state, which keeps the hare on state_net when PERIOD begins and makes a
  // self-loop measure as period 1.
  assign core_stop = find_hit | period_hit | step_abort;

  assign bus.start_s0      = start_s0_q & ~core_stop;
  assign bus.start_s1      = start_s1_q & ~core_stop;
  assign bus.s1_single     = s1_single_q;
  assign bus.init_state    = init_state_q;
  assign bus.fifo_out_data = out_data_q;
  // A pulse register frozen high while start is low must not repeat the
  // FIFO access or the core load, so these three are masked by start.
  assign bus.fifo_in_re    = fifo_in_re_q  & start;
  assign bus.fifo_out_we   = fifo_out_we_q & start;
  assign bus.reset_nos     = reset_nos_q   & start;
  assign done              = done_q;

  // NOTE: every register here uses non-blocking assignments, so all reads in
  // a cycle see the pre-edge values regardless of statement order; a later
  // assignment to the same register in the same branch overrides an earlier
  // default.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      phase         <= 1'b0;
      fifo_in_re_q  <= 1'b0;
      fifo_out_we_q <= 1'b0;
      reset_nos_q   <= 1'b0;
      start_s0_q    <= 1'b0;
      start_s1_q    <= 1'b0;
      s1_single_q   <= 1'b0;
      init_state_q  <= '0;
      end_reg       <= '0;
      state_net     <= '0;
      transient     <= '0;
      period        <= '0;
      timeout_q     <= 1'b0;
      out_data_q    <= '0;
      drain_seen    <= 1'b0;
      done_q        <= 1'b0;
    end else if (start) begin
      // Pulse outputs default low; states below raise them for one cycle.
      fifo_in_re_q  <= 1'b0;
      fifo_out_we_q <= 1'b0;
      reset_nos_q   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!bus.fifo_in_empty) begin
            fifo_in_re_q <= 1'b1;
            phase        <= 1'b0;
            state        <= ST_GET_STATE;
          end else if (bus.end_data_in) begin
            drain_seen <= 1'b0;
            state      <= ST_DONE;
          end
        end

        ST_GET_STATE: begin
          // The FIFO presents the word one cycle after the read pulse.
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            init_state_q <= bus.fifo_in_data[NODES-1:0];
            end_reg      <= bus.fifo_in_data[2*NODES-1:NODES];
            state        <= ST_RESET_NOS;
          end
        end

        ST_RESET_NOS: begin
          reset_nos_q <= 1'b1;
          transient   <= '0;
          period      <= '0;
          timeout_q   <= 1'b0;
          state       <= ST_START_NOS;
        end

        ST_START_NOS: begin
          start_s0_q  <= 1'b1;
          start_s1_q  <= 1'b1;
          s1_single_q <= 1'b0;
          phase       <= 1'b0;
          state       <= ST_FIND;
        end

        ST_FIND: begin
          phase <= 1'b1;
          if (find_hit) begin
            state_net <= bus.s0;
            // The tortoise never left the cycle: no transient at all.
            if (bus.s0 == init_state_q) begin
              transient <= '0;
            end
            // Tortoise parks; the hare keeps running, now one step per cycle.
            start_s0_q  <= 1'b0;
            start_s1_q  <= 1'b1;
            s1_single_q <= 1'b1;
            phase       <= 1'b0;
            state       <= ST_PERIOD;
          end else if (step_abort) begin
            state_net  <= bus.s0;
            timeout_q  <= 1'b1;
            start_s0_q <= 1'b0;
            start_s1_q <= 1'b0;
            state      <= ST_EMIT;
          end else begin
            transient <= transient + 1'b1;
          end
        end

        ST_PERIOD: begin
          phase <= 1'b1;
          if (period_hit) begin
            start_s1_q <= 1'b0;
            state      <= ST_EMIT;
          end else if (step_abort) begin
            state_net  <= bus.s0;
            timeout_q  <= 1'b1;
            start_s1_q <= 1'b0;
            state      <= ST_EMIT;
          end else begin
            period <= period + 1'b1;
          end
        end

        ST_EMIT: begin
          if (!bus.fifo_out_full) begin
            fifo_out_we_q <= 1'b1;
            out_data_q    <= {timeout_q, state_net, transient, period};
            // Strict less-than: a reversed range yields one record, and an
            // all-ones end stops without wrapping init_state.
            if (init_state_q < end_reg) begin
              init_state_q <= init_state_q + 1'b1;
              state        <= ST_RESET_NOS;
            end else begin
              drain_seen <= 1'b0;
              state      <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (!bus.fifo_in_empty) begin
            fifo_in_re_q <= 1'b1;
            phase        <= 1'b0;
            drain_seen   <= 1'b0;
            state        <= ST_GET_STATE;
          end else if (bus.end_data_in && bus.fifo_out_empty) begin
            // Drain condition must hold on two consecutive cycles.
            if (drain_seen) begin
              done_q <= 1'b1;
            end
            drain_seen <= 1'b1;
          end else begin
            drain_seen <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
